// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bus bridge: FSM encoding and defaults.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int TIMEOUT_DEF = 255;
    localparam int TO_W_DEF    = 8;

    // Word accesses only: both low address bits must be clear.
    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_bridge_bus_timer.sv
// Wait-cycle counter for the bus bridge: clears at transaction start, counts
// while enabled and saturates at TIMEOUT-1, which is reported as terminal count.
module bus_timer #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [TO_W-1:0] TC = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] r_count;

    assign o_tc = (r_count == TC);

    // Counter: clear has priority; hold at terminal count so it never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_tc) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns single-cycle core loads/stores into req/ready bus
// transactions, stalling the core until each access completes or times out.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int AW      = 32,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TO_W    = TO_W_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          memread,
    input  logic          memwrite,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          stall,
    output logic          err,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [31:0]   bus_wdata,
    input  logic          bus_ready,
    input  logic [31:0]   bus_rdata
);

    state_t          r_state;
    state_t          w_next;
    logic            w_access;
    logic            w_aligned;
    logic            w_start;
    logic            w_tc;
    logic [31:0]     r_rdata;
    logic            r_err;
    logic            r_bus_req;
    logic            r_bus_we;
    logic [AW-1:0]   r_bus_addr;
    logic [31:0]     r_bus_wdata;

    assign w_access  = memread | memwrite;
    assign w_aligned = is_aligned(addr[1:0]);
    assign w_start   = (r_state == ST_IDLE) && w_access && w_aligned;

    assign rdata     = r_rdata;
    assign err       = r_err;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;

    bus_timer #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_start),
        .i_en    (r_state == ST_BUSY),
        .o_tc    (w_tc)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and stall: stall is raised the same cycle a valid access shows up.
    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    stall  = 1'b1;
                    w_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (bus_ready || w_tc) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Bus request, captured access, load data and the single-cycle error pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_access && w_aligned) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= memwrite;
                        r_bus_addr  <= {addr[AW-1:2], 2'b00};
                        r_bus_wdata <= wdata;
                        // Read+write together runs as a write but is still flagged.
                        r_err       <= memread & memwrite;
                    end else if (w_access) begin
                        r_err <= 1'b1;
                        if (!memwrite) begin
                            r_rdata <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (bus_ready) begin
                        r_bus_req <= 1'b0;
                        if (!r_bus_we) begin
                            r_rdata <= bus_rdata;
                        end
                    end else if (w_tc) begin
                        r_bus_req <= 1'b0;
                        r_err     <= 1'b1;
                        if (!r_bus_we) begin
                            r_rdata <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge with a short timeout and a cycle-driven slave.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          err_cnt = 0;
    logic [31:0] model_rdata = 32'h0;
    logic [31:0] exp_q[$];

    dmem_bridge #(
        .AW      (32),
        .TIMEOUT (4),
        .TO_W    (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .memread   (memread),
        .memwrite  (memwrite),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .err       (err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1);
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            memread   = 1'b0;
            memwrite  = 1'b0;
            bus_ready = 1'b0;
        end
    endtask

    // One core access; waits < 0 means the slave never answers.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input int waits, input logic [31:0] sdata,
                          output int n_stall, output int n_req, output bit stable,
                          output bit we_ok, output logic [31:0] a0, output logic [31:0] w0);
        int          busy;
        bit          first;
        bit          done;
        logic [31:0] exp;
        n_stall = 0; n_req = 0; stable = 1'b1; we_ok = 1'b1;
        busy = 0; first = 1'b1; done = 1'b0; a0 = 32'h0; w0 = 32'h0;
        if (!wr) model_rdata = (a[1:0] != 2'b00 || waits < 0) ? 32'h0 : sdata;
        exp_q.push_back(model_rdata);
        @(negedge clk);
        memread = rd; memwrite = wr; addr = a; wdata = wd; bus_ready = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (stall === 1'b1) n_stall++;
            if (bus_req === 1'b1) begin
                n_req++;
                if (first) begin
                    a0 = bus_addr; w0 = bus_wdata; first = 1'b0;
                end else if (bus_addr !== a0 || bus_wdata !== w0) begin
                    stable = 1'b0;
                end
                if (bus_we !== wr) we_ok = 1'b0;
                bus_ready = (waits >= 0 && busy == waits);
                bus_rdata = bus_ready ? sdata : 32'hDEAD_BEEF;
                busy++;
            end else begin
                bus_ready = 1'b0;
                bus_rdata = 32'hBAD0_BAD0;
            end
            if (stall === 1'b0) done = 1'b1;
            else @(negedge clk);
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL access_done a=%h: actual=stall stuck high required=stall released", a);
        end
        if (a[1:0] != 2'b00) begin
            @(negedge clk);
            memread = 1'b0; memwrite = 1'b0;
            #1;
        end
        exp = exp_q.pop_front();
        n_tests++;
        if (rdata !== exp) begin
            n_fail++;
            $display("FAIL rdata a=%h: actual=%h required=%h", a, rdata, exp);
        end
    endtask

    task automatic test_reset;
        #1;
        n_tests++;
        if ({rdata, bus_req, bus_we, bus_addr, bus_wdata, err, stall} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: actual rdata=%h req=%b we=%b addr=%h wd=%h err=%b stall=%b required=all 0",
                     rdata, bus_req, bus_we, bus_addr, bus_wdata, err, stall);
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        #1;
        n_tests++;
        if ({bus_req, err, stall} !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset_idle: actual req=%b err=%b stall=%b required=000", bus_req, err, stall);
        end
    endtask

    task automatic test_load;
        int n_stall, n_req, e0; bit stable, we_ok; logic [31:0] a0, w0;
        e0 = err_cnt;
        access(1'b1, 1'b0, 32'h40, 32'h0, 0, 32'h1234_5678, n_stall, n_req, stable, we_ok, a0, w0);
        n_tests++;
        if (n_stall != 2) begin n_fail++; $display("FAIL load_stall: actual=%0d required=2", n_stall); end
        n_tests++;
        if (n_req != 1 || !we_ok || a0 !== 32'h40) begin
            n_fail++;
            $display("FAIL load_bus: actual req_cycles=%0d we_ok=%0b addr=%h required=1 1 00000040", n_req, we_ok, a0);
        end
        idle(2);
        n_tests++;
        if (err_cnt != e0) begin n_fail++; $display("FAIL load_err: actual=%0d required=0", err_cnt - e0); end
    endtask

    task automatic test_store;
        int n_stall, n_req, e0; bit stable, we_ok; logic [31:0] a0, w0;
        e0 = err_cnt;
        access(1'b0, 1'b1, 32'h44, 32'hCAFE_F00D, 3, 32'h0, n_stall, n_req, stable, we_ok, a0, w0);
        n_tests++;
        if (n_req != 4) begin n_fail++; $display("FAIL store_req_cycles: actual=%0d required=4", n_req); end
        n_tests++;
        if (n_stall != 5) begin n_fail++; $display("FAIL store_stall: actual=%0d required=5", n_stall); end
        n_tests++;
        if (!stable || !we_ok || a0 !== 32'h44 || w0 !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL store_bus: actual stable=%0b we_ok=%0b addr=%h wd=%h required=1 1 00000044 cafef00d",
                     stable, we_ok, a0, w0);
        end
        idle(2);
        n_tests++;
        if (err_cnt != e0) begin n_fail++; $display("FAIL store_err: actual=%0d required=0", err_cnt - e0); end
    endtask

    task automatic test_misaligned;
        int n_stall, n_req, e0; bit stable, we_ok; logic [31:0] a0, w0;
        e0 = err_cnt;
        access(1'b1, 1'b0, 32'h42, 32'h0, 0, 32'h5555_AAAA, n_stall, n_req, stable, we_ok, a0, w0);
        n_tests++;
        if (n_stall != 0 || n_req != 0) begin
            n_fail++;
            $display("FAIL misaligned_bus: actual stall=%0d req=%0d required=0 0", n_stall, n_req);
        end
        idle(3);
        n_tests++;
        if (err_cnt != e0 + 1) begin n_fail++; $display("FAIL misaligned_err: actual=%0d required=1", err_cnt - e0); end
    endtask

    task automatic test_timeout;
        int n_stall, n_req, e0; bit stable, we_ok; logic [31:0] a0, w0;
        // Non-zero load first so the abort visibly clears rdata.
        access(1'b1, 1'b0, 32'h4C, 32'h0, 1, 32'h0BAD_F00D, n_stall, n_req, stable, we_ok, a0, w0);
        idle(1);
        e0 = err_cnt;
        access(1'b1, 1'b0, 32'h48, 32'h0, -1, 32'h0, n_stall, n_req, stable, we_ok, a0, w0);
        n_tests++;
        if (n_req != 4) begin n_fail++; $display("FAIL timeout_req_cycles: actual=%0d required=4", n_req); end
        n_tests++;
        if (n_stall != 5) begin n_fail++; $display("FAIL timeout_stall: actual=%0d required=5", n_stall); end
        idle(3);
        n_tests++;
        if (err_cnt != e0 + 1) begin n_fail++; $display("FAIL timeout_err: actual=%0d required=1", err_cnt - e0); end
    endtask

    task automatic test_back_to_back;
        int s1, s2, s3, r3, e0; int n_req; bit stable, we_ok; logic [31:0] a0, w0;
        e0 = err_cnt;
        access(1'b1, 1'b0, 32'h50, 32'h0, 0, 32'hA1A1_0001, s1, n_req, stable, we_ok, a0, w0);
        access(1'b1, 1'b0, 32'h54, 32'h0, 1, 32'hB2B2_0002, s2, n_req, stable, we_ok, a0, w0);
        n_tests++;
        if (s1 != 2 || s2 != 3 || a0 !== 32'h54) begin
            n_fail++;
            $display("FAIL b2b_loads: actual stall1=%0d stall2=%0d addr2=%h required=2 3 00000054", s1, s2, a0);
        end
        access(1'b1, 1'b1, 32'h58, 32'h7777_8888, 1, 32'hEEEE_EEEE, s3, r3, stable, we_ok, a0, w0);
        n_tests++;
        if (!we_ok || r3 != 2 || w0 !== 32'h7777_8888) begin
            n_fail++;
            $display("FAIL conflict_write: actual we_ok=%0b req=%0d wd=%h required=1 2 77778888", we_ok, r3, w0);
        end
        idle(3);
        n_tests++;
        if (err_cnt != e0 + 1) begin n_fail++; $display("FAIL conflict_err: actual=%0d required=1", err_cnt - e0); end
    endtask

    task automatic test_reset_mid;
        int n_stall, n_req; bit stable, we_ok; logic [31:0] a0, w0;
        @(negedge clk);
        memread = 1'b1; memwrite = 1'b0; addr = 32'h60; bus_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (bus_req !== 1'b1) begin n_fail++; $display("FAIL midreset_busy: actual req=%b required=1", bus_req); end
        memread = 1'b0;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({rdata, bus_req, bus_we, bus_addr, bus_wdata, err, stall} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: actual rdata=%h req=%b addr=%h err=%b stall=%b required=all 0",
                     rdata, bus_req, bus_addr, err, stall);
        end
        // A fresh aligned access raises stall only from IDLE.
        memread = 1'b1;
        #1;
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL midreset_idle: actual stall=%b required=1", stall); end
        memread = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_rdata = 32'h0;
        exp_q.delete();
        idle(1);
        access(1'b1, 1'b0, 32'h64, 32'h0, 2, 32'h0F0F_1234, n_stall, n_req, stable, we_ok, a0, w0);
        n_tests++;
        if (n_stall != 4 || n_req != 3) begin
            n_fail++;
            $display("FAIL recover_load: actual stall=%0d req=%0d required=4 3", n_stall, n_req);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        test_reset();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
